// File: rtl/axis_dsm_cic_decimator.sv
// CIC decimator for a 1-bit delta-sigma stream: N integrators at the input rate,
// N combs at the output rate, scaled and saturated to a signed WIDTH-bit AXI-Stream sample.
module axis_dsm_cic_decimator #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned N      = 3,
  parameter int unsigned R_LOG2 = 6
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  output logic signed [WIDTH-1:0] m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  input  logic                    m_axis_data_tready
);

  localparam int unsigned GW  = N * R_LOG2;
  localparam int unsigned IW  = GW + 2;
  localparam int unsigned SW  = IW + WIDTH;
  localparam int          SH  = int'(GW) - int'(WIDTH) + 1;
  localparam int unsigned RSH = (SH > 0) ? SH : 0;
  localparam int unsigned LSH = (SH < 0) ? -SH : 0;

  localparam logic signed [IW-1:0] STEP_POS = IW'(1);
  localparam logic signed [IW-1:0] STEP_NEG = '1;
  localparam logic signed [SW-1:0] MAX_S    = SW'((longint'(1) <<< (WIDTH - 1)) - longint'(1));
  localparam logic signed [SW-1:0] MIN_S    = SW'(-(longint'(1) <<< (WIDTH - 1)));

  logic signed [IW-1:0]    integ_q [N];
  logic signed [IW-1:0]    integ_d [N];
  logic signed [IW-1:0]    comb_q  [N];
  logic signed [IW-1:0]    comb_d  [N];
  logic signed [IW-1:0]    acc;
  logic signed [IW-1:0]    y;
  logic signed [SW-1:0]    scaled;
  logic signed [WIDTH-1:0] sat;
  logic [R_LOG2-1:0]       cnt_q;
  logic                    last;
  logic                    in_hs;
  logic                    load;

  assign last  = &cnt_q;
  // Stall input only when the frame-closing sample would overwrite an unaccepted output.
  assign s_axis_data_tready = ~(m_axis_data_tvalid & ~m_axis_data_tready & last);
  assign in_hs = s_axis_data_tvalid & s_axis_data_tready;
  assign load  = in_hs & last;

  // Integrator cascade including the current sample, then comb cascade on its output.
  always_comb begin
    acc = s_axis_data_tdata ? STEP_POS : STEP_NEG;
    for (int k = 0; k < int'(N); k++) begin
      acc        = integ_q[k] + acc;
      integ_d[k] = acc;
    end
    for (int k = 0; k < int'(N); k++) begin
      comb_d[k] = acc;
      acc       = acc - comb_q[k];
    end
    y = acc;
  end

  // Align gain R**N to WIDTH-1 fractional bits, then clamp to the output range.
  always_comb begin
    scaled = (SW'(y) >>> RSH) <<< LSH;
    sat    = scaled[WIDTH-1:0];
    if (scaled > MAX_S) begin
      sat = WIDTH'(MAX_S);
    end else if (scaled < MIN_S) begin
      sat = WIDTH'(MIN_S);
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < int'(N); k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
      end
      cnt_q              <= '0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else begin
      if (in_hs) begin
        integ_q <= integ_d;
        cnt_q   <= cnt_q + R_LOG2'(1);
      end
      if (load) begin
        comb_q             <= comb_d;
        m_axis_data_tdata  <= sat;
        m_axis_data_tvalid <= 1'b1;
      end else if (m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_dsm_cic_decimator.sv
// Bench for axis_dsm_cic_decimator: reference is a direct FIR convolution with the
// CIC impulse response (boxcar of length R convolved N times), driven through a handshake model.
module tb_axis_dsm_cic_decimator;

  localparam int W   = 16;
  localparam int NN  = 3;
  localparam int RL  = 6;
  localparam int R   = 1 << RL;
  localparam int HL  = NN * (R - 1) + 1;
  localparam int SH  = NN * RL - (W - 1);

  logic                aclk = 1'b0;
  logic                arst = 1'b1;
  logic                s_d  = 1'b0;
  logic                s_v  = 1'b0;
  logic                s_tready;
  logic signed [W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_r  = 1'b0;

  axis_dsm_cic_decimator #(.WIDTH(W), .N(NN), .R_LOG2(RL)) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (s_d),
    .s_axis_data_tvalid (s_v),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_r)
  );

  always #5 aclk = ~aclk;

  int h [HL];
  int hist [$];
  int expq [$];
  int cnt, out_idx, acc_total, out_total;
  int const_chk, const_val;
  int n_vec, n_err;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_out();
    longint y = 0;
    longint s;
    for (int j = 0; j < HL; j++)
      if (j < hist.size()) y += longint'(h[j]) * longint'(hist[hist.size() - 1 - j]);
    s = (SH >= 0) ? (y >>> SH) : (y <<< (-SH));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic cycle(input bit sv, input bit sd, input bit mr);
    bit exp_valid, exp_tready, in_hs;
    @(negedge aclk);
    s_v = sv; s_d = sd; m_r = mr;
    #1;
    exp_valid  = expq.size() > 0;
    exp_tready = !(exp_valid && !mr && cnt == R - 1);
    check("m_tvalid", m_tvalid, int'(exp_valid));
    if (exp_valid) check("m_tdata", m_tdata, expq[0]);
    check("s_tready", s_tready, int'(exp_tready));
    if (exp_valid && mr && const_chk != 0 && out_idx >= NN) check("steady", m_tdata, const_val);
    if (m_tvalid === 1'b1 && mr) out_total++;
    in_hs = sv && exp_tready;
    @(posedge aclk);
    if (exp_valid && mr) begin
      void'(expq.pop_front());
      out_idx++;
    end
    if (in_hs) begin
      hist.push_back(sd ? 1 : -1);
      if (hist.size() > HL) void'(hist.pop_front());
      acc_total++;
      cnt++;
      if (cnt == R) begin
        cnt = 0;
        expq.push_back(ref_out());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    s_v = 1'b0; m_r = 1'b0;
    #1 arst = 1'b1;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tready", s_tready, 1);
    hist.delete(); expq.delete();
    cnt = 0; out_idx = 0;
    #1 arst = 1'b0;
  endtask

  initial begin
    int tmp [HL];
    int base_acc, base_out, guard;
    n_vec = 0; n_err = 0; cnt = 0; out_idx = 0; acc_total = 0; out_total = 0;
    const_chk = 0; const_val = 0;

    // Impulse response: boxcar of length R convolved with itself N times.
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    for (int s = 0; s < NN; s++) begin
      for (int i = 0; i < HL; i++) begin
        tmp[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) tmp[i] += h[i - k];
      end
      h = tmp;
    end

    #12;
    check("init_tvalid", m_tvalid, 0);
    check("init_tdata", m_tdata, 0);
    check("init_tready", s_tready, 1);
    #1 arst = 1'b0;

    // Constant ones, full rate.
    const_chk = 1; const_val = 32767;
    for (int i = 0; i < 6 * R + 4; i++) cycle(1'b1, 1'b1, 1'b1);
    // Constant zeros.
    do_reset();
    const_val = -32768;
    for (int i = 0; i < 6 * R + 4; i++) cycle(1'b1, 1'b0, 1'b1);
    // Alternating 1,0.
    do_reset();
    const_val = 0;
    for (int i = 0; i < 6 * R + 4; i++) cycle(1'b1, i[0] == 1'b0, 1'b1);
    const_chk = 0;

    // Random bits with random input gaps and random downstream backpressure.
    do_reset();
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);

    // Long downstream stall under constant input, then release.
    do_reset();
    base_acc = acc_total; base_out = out_total;
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b0);
    check("stall_accepted", acc_total - base_acc, 2 * R - 1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
    check("out_count", out_total - base_out, (acc_total - base_acc) / R);

    // Reset mid-frame at counter 30, then a fresh frame.
    guard = 0;
    while (cnt != 30 && guard < 1000) begin
      cycle($urandom_range(0, 1) != 0, 1'($urandom), 1'b1);
      guard++;
    end
    check("reach_cnt30", cnt, 30);
    do_reset();
    base_acc = acc_total; base_out = out_total;
    for (int i = 0; i < 3 * R + 10; i++) cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
    check("post_rst_count", out_total - base_out, (acc_total - base_acc) / R);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_dsm_cic_decimator.md
AXIS_DSM_CIC_DECIMATOR -- requirements
Module: axis_dsm_cic_decimator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning signed PCM output width in bits.
REQ-002 The block SHALL have parameter N, default 3, meaning CIC order, legal range 1..5.
REQ-003 The block SHALL have parameter R_LOG2, default 6, meaning log2 of the decimation ratio R (R = 2**R_LOG2), legal range 1..8.
REQ-004 The block SHALL have port aclk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port arst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port s_axis_data_tdata, input, 1 bit, delta-sigma bitstream sample.
REQ-007 The block SHALL have port s_axis_data_tvalid, input, 1 bit, input sample valid.
REQ-008 The block SHALL have port s_axis_data_tready, output, 1 bit, block can accept an input sample.
REQ-009 The block SHALL have port m_axis_data_tdata, output, WIDTH bits signed, decimated PCM sample.
REQ-010 The block SHALL have port m_axis_data_tvalid, output, 1 bit, output sample valid.
REQ-011 The block SHALL have port m_axis_data_tready, input, 1 bit, downstream accepts the output sample.

Function
REQ-012 The block SHALL treat an input handshake (tvalid and tready high on a rising edge) as one bitstream sample: bit 1 maps to +1, bit 0 maps to -1.
REQ-013 The block SHALL contain N cascaded integrators, each IW = N*R_LOG2+2 bits two's complement, updated only on input handshakes; wrap-around is permitted and intended.
REQ-014 The block SHALL contain a decimation counter 0..R-1, incremented on each input handshake and wrapping from R-1 to 0.
REQ-015 On the handshake where the counter equals R-1, the block SHALL compute N cascaded comb stages (differential delay 1) from the last-integrator value including that sample, and update the comb delay registers.
REQ-016 The comb result y lies in [-2**(N*R_LOG2), +2**(N*R_LOG2)]; the block SHALL scale it to WIDTH-1 fractional bits: arithmetic right shift by N*R_LOG2-(WIDTH-1) when that is >= 0, otherwise left shift by the magnitude.
REQ-017 The block SHALL saturate the scaled value to [-2**(WIDTH-1), 2**(WIDTH-1)-1] before output.
REQ-018 The block SHALL load the saturated value into the output register and assert m_axis_data_tvalid on the rising edge following the R-th input handshake of each frame (latency 1 cycle).
REQ-019 m_axis_data_tvalid SHALL stay high with m_axis_data_tdata stable until a handshake with m_axis_data_tready; it SHALL then deassert unless a new sample is loaded on the same edge.
REQ-020 s_axis_data_tready SHALL be low exactly when m_axis_data_tvalid is high, m_axis_data_tready is low, and the counter equals R-1; otherwise high. No output sample is ever dropped or overwritten.
REQ-021 When an output handshake and a new-sample load coincide, the block SHALL present the new sample and keep tvalid high.
REQ-022 Input tvalid low SHALL freeze integrators, counter and combs.
REQ-023 The first N output samples after reset are filter transient; the block SHALL emit them without marking.

Reset
REQ-024 arst high SHALL asynchronously clear integrators, comb delays, counter, output register to 0 and m_axis_data_tvalid to 0, including mid-frame; s_axis_data_tready SHALL be 1 while arst is high and after release.
REQ-025 The first output after arst release SHALL follow exactly R accepted input samples.

Verification
REQ-026 Defaults, constant bit 1, m_tready=1 -> outputs after the 3rd equal 32767 (saturated), one every 64 accepted inputs.
REQ-027 Defaults, constant bit 0 -> outputs after the 3rd equal -32768.
REQ-028 Defaults, alternating 1,0 -> outputs after the 3rd equal 0.
REQ-029 Defaults, 2 kHz sine through the second-order DSM DAC at 100 MHz, 5 periods -> decoded PCM tracks the DAC input within +-64 LSB after group-delay alignment.
REQ-030 m_tready held low for 200 cycles under constant input -> s_tready drops at counter 63, tdata held stable, no sample lost after release; output count equals accepted inputs/64.
REQ-031 arst pulsed at counter 30 mid-frame -> m_tvalid=0, tdata=0 immediately; next output after exactly 64 further accepted inputs.
